multi_cycle_ctrl: RTL
=====================

Name: multi_cycle_ctrl

Overview:
Control FSM that sequences the existing datapath (PC, IR, register file, ALU) over several cycles per instruction, replacing single-cycle control. It handshakes with instruction memory, classifies the opcode, and drives the per-cycle datapath enables and ALU operation. It also counts retired instructions and flags illegal opcodes and fetch timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter.
TIMEOUT, 15, cycles imem_req_o may stay outstanding without imem_ack_i before fetch_err_o fires; legal range 1..255.

Ports:
clk_i  input  1  clock.
rst_i  input  1  synchronous, active-high reset.
imem_req_o  output  1  instruction fetch request; held high until ack.
imem_ack_i  input  1  instruction memory data valid, single-cycle pulse.
instr_op_i  input  6  opcode field from IR; stable from DECODE onward.
zero_i  input  1  ALU zero flag.
IR_write_o  output  1  load IR.
PC_write_o  output  1  load PC.
PC_src_o  output  1  0 = PC+4, 1 = branch target.
RegWrite_o  output  1  register file write enable.
RegDst_o  output  1  1 = rd, 0 = rt.
ALUSrc_o  output  1  1 = immediate, 0 = rt.
ALU_op_o  output  3  ALU operation class.
state_o  output  3  current state, for debug.
illegal_o  output  1  one-cycle pulse on an unsupported opcode.
fetch_err_o  output  1  one-cycle pulse on a fetch timeout.
retired_cnt_o  output  CNT_W  count of retired instructions.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, BRANCH=5. Codes 6 and 7 go to IDLE on the next cycle.
- Reset: state IDLE, retired_cnt_o=0, timeout counter=0. In IDLE every output is 0 except state_o.
- IDLE -> FETCH unconditionally.
- FETCH:
  - imem_req_o=1.
  - On imem_ack_i=1: IR_write_o=1, PC_write_o=1, PC_src_o=0 in the same cycle, then go to DECODE.
  - Otherwise increment the timeout counter. At count==TIMEOUT-1 without ack: pulse fetch_err_o, clear the counter, stay in FETCH (retry).
  - The counter clears on leaving FETCH.
- DECODE: latch the opcode class.
  - R-type 000000, addi 001000, slti 001010, sltiu 001011, ori 001101, lui 001111 -> EXEC.
  - beq 000100, bne 000101 -> BRANCH.
  - Any other opcode -> illegal_o=1 this cycle, go to FETCH, no retire.
- ALU_op_o (driven in DECODE, EXEC, WB, BRANCH; 0 in IDLE and FETCH): R 010, addi 100, slti/sltiu 111, ori 101, lui 110, beq 011, bne 001.
- RegDst_o=1 only for R-type. ALUSrc_o=1 for the immediate class. Both are held through EXEC and WB.
- EXEC: ALU evaluates; no enables asserted; go to WB.
- WB: RegWrite_o=1 for exactly one cycle; retire; go to FETCH.
- BRANCH: PC_src_o=1; go to FETCH; retire.
  - PC_write_o=1 iff (beq and zero_i) or (bne and !zero_i).
  - The retire happens whether or not the branch is taken.
- Retire: retired_cnt_o increments by 1 on the cycle after a WB or BRANCH cycle is left, and wraps modulo 2^CNT_W.
- Latency with zero-wait ack: R/I-type 4 cycles (FETCH, DECODE, EXEC, WB); branch 3 cycles; illegal opcode 2 cycles.
- imem_ack_i outside FETCH is ignored.
- rst_i high mid-instruction: the next state is IDLE and the counters clear. No write enable may assert in the cycle after rst_i is sampled high.
- Simultaneous ack and timeout expiry: the ack wins and fetch_err_o stays 0.

Test Plan:
- Reset 3 cycles, then addi with ack on the first FETCH cycle -> states 0,1,2,3,4,1. RegWrite_o=1 only in the WB cycle. ALU_op_o=100, ALUSrc_o=1, RegDst_o=0. retired_cnt_o=1.
- beq with zero_i=1 -> PC_write_o=1, PC_src_o=1 in BRANCH. Repeat with zero_i=0 -> PC_write_o=0. Both cases retire (count 2). bne with zero_i=0 -> taken.
- Opcode 100011 -> illegal_o pulses once in DECODE, state returns to FETCH, retired_cnt_o unchanged, no RegWrite_o.
- Hold imem_ack_i=0 for 35 cycles with TIMEOUT=15 -> fetch_err_o pulses on cycles 15 and 30 of FETCH. Then ack -> IR_write_o=1 and progress to DECODE. Ack on exactly cycle 15 -> no fetch_err_o.
- Assert rst_i during EXEC of an R-type -> next state IDLE, retired_cnt_o=0, RegWrite_o never asserted.
- CNT_W=4, run 17 back-to-back R-type instructions -> retired_cnt_o wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Bundles the control FSM's instruction-memory handshake, datapath controls and status.
// master = controller side, slave = memory/datapath side.
interface multi_cycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             imem_req_o;
    logic             imem_ack_i;
    logic [5:0]       instr_op_i;
    logic             zero_i;
    logic             IR_write_o;
    logic             PC_write_o;
    logic             PC_src_o;
    logic             RegWrite_o;
    logic             RegDst_o;
    logic             ALUSrc_o;
    logic [2:0]       ALU_op_o;
    logic [2:0]       state_o;
    logic             illegal_o;
    logic             fetch_err_o;
    logic [CNT_W-1:0] retired_cnt_o;

    modport master (
        output imem_req_o, IR_write_o, PC_write_o, PC_src_o, RegWrite_o, RegDst_o, ALUSrc_o,
               ALU_op_o, state_o, illegal_o, fetch_err_o, retired_cnt_o,
        input  imem_ack_i, instr_op_i, zero_i
    );

    modport slave (
        input  imem_req_o, IR_write_o, PC_write_o, PC_src_o, RegWrite_o, RegDst_o, ALUSrc_o,
               ALU_op_o, state_o, illegal_o, fetch_err_o, retired_cnt_o,
        output imem_ack_i, instr_op_i, zero_i
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: fetch handshake with timeout, opcode classification,
// per-state datapath enables and a retired-instruction counter.
module multi_cycle_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                clk_i,
    input logic                rst_i,
    multi_cycle_ctrl_if.master bus
);

    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    localparam logic [2:0] AluR    = 3'b010;
    localparam logic [2:0] AluAddi = 3'b100;
    localparam logic [2:0] AluSlt  = 3'b111;
    localparam logic [2:0] AluOri  = 3'b101;
    localparam logic [2:0] AluLui  = 3'b110;
    localparam logic [2:0] AluBeq  = 3'b011;
    localparam logic [2:0] AluBne  = 3'b001;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StWb     = 3'd4,
        StBranch = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             reg_dst_q, reg_dst_d;
    logic             alu_src_q, alu_src_d;

    logic [2:0] dec_alu_op;
    logic       dec_reg_dst, dec_alu_src, dec_exec, dec_branch;

    always_comb begin
        dec_alu_op  = 3'b000;
        dec_reg_dst = 1'b0;
        dec_alu_src = 1'b0;
        dec_exec    = 1'b0;
        dec_branch  = 1'b0;
        case (bus.instr_op_i)
            6'b000000: begin dec_alu_op = AluR;    dec_reg_dst = 1'b1; dec_exec = 1'b1; end
            6'b001000: begin dec_alu_op = AluAddi; dec_alu_src = 1'b1; dec_exec = 1'b1; end
            6'b001010,
            6'b001011: begin dec_alu_op = AluSlt;  dec_alu_src = 1'b1; dec_exec = 1'b1; end
            6'b001101: begin dec_alu_op = AluOri;  dec_alu_src = 1'b1; dec_exec = 1'b1; end
            6'b001111: begin dec_alu_op = AluLui;  dec_alu_src = 1'b1; dec_exec = 1'b1; end
            6'b000100: begin dec_alu_op = AluBeq;  dec_branch = 1'b1; end
            6'b000101: begin dec_alu_op = AluBne;  dec_branch = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = 8'd0;
        retired_d = retired_q;
        alu_op_d  = alu_op_q;
        reg_dst_d = reg_dst_q;
        alu_src_d = alu_src_q;

        bus.imem_req_o  = 1'b0;
        bus.IR_write_o  = 1'b0;
        bus.PC_write_o  = 1'b0;
        bus.PC_src_o    = 1'b0;
        bus.RegWrite_o  = 1'b0;
        bus.RegDst_o    = 1'b0;
        bus.ALUSrc_o    = 1'b0;
        bus.ALU_op_o    = 3'b000;
        bus.illegal_o   = 1'b0;
        bus.fetch_err_o = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.imem_req_o = 1'b1;
                // An ack in the expiry cycle takes priority over the timeout.
                if (bus.imem_ack_i) begin
                    bus.IR_write_o = 1'b1;
                    bus.PC_write_o = 1'b1;
                    state_d        = StDecode;
                end else if (tmo_q == TmoLast) begin
                    bus.fetch_err_o = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StDecode: begin
                bus.ALU_op_o = dec_alu_op;
                bus.RegDst_o = dec_reg_dst;
                bus.ALUSrc_o = dec_alu_src;
                alu_op_d     = dec_alu_op;
                reg_dst_d    = dec_reg_dst;
                alu_src_d    = dec_alu_src;
                if (dec_exec) begin
                    state_d = StExec;
                end else if (dec_branch) begin
                    state_d = StBranch;
                end else begin
                    bus.illegal_o = 1'b1;
                    state_d       = StFetch;
                end
            end
            StExec: begin
                bus.ALU_op_o = alu_op_q;
                bus.RegDst_o = reg_dst_q;
                bus.ALUSrc_o = alu_src_q;
                state_d      = StWb;
            end
            StWb: begin
                bus.ALU_op_o   = alu_op_q;
                bus.RegDst_o   = reg_dst_q;
                bus.ALUSrc_o   = alu_src_q;
                bus.RegWrite_o = 1'b1;
                retired_d      = retired_q + CNT_W'(1);
                state_d        = StFetch;
            end
            StBranch: begin
                bus.ALU_op_o   = alu_op_q;
                bus.PC_src_o   = 1'b1;
                bus.PC_write_o = (alu_op_q == AluBeq) ? bus.zero_i : ~bus.zero_i;
                retired_d      = retired_q + CNT_W'(1);
                state_d        = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            tmo_q     <= 8'd0;
            retired_q <= '0;
            alu_op_q  <= 3'b000;
            reg_dst_q <= 1'b0;
            alu_src_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
            alu_op_q  <= alu_op_d;
            reg_dst_q <= reg_dst_d;
            alu_src_q <= alu_src_d;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.retired_cnt_o = retired_q;

endmodule
